decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_if.sv | 34 +++
 rtl/decode_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Decode stage handshake bundle: upstream instruction/PC in, decoded head record out.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
           out_rs1, out_rs2, out_rd, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
           out_rs1, out_rs2, out_rd, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV instruction decode stage with a DEPTH-entry in-order record buffer.
// Optional feature: define DECODE_ILLEGAL_EN to flag and buffer illegal instructions.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  decode_stage_if.slave bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_INV = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      fmt;
`ifdef DECODE_ILLEGAL_EN
    logic            illegal;
`endif
  } rec_t;

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  rec_t          mem [DEPTH];
  rec_t          rec_d;
  rec_t          out_rec;
  logic [31:0]   instr;
  logic          head_vld;
  logic          push;
  logic          pop;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    sext32 = XLEN'($signed(v));
  endfunction

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign instr = bus.in_instr;

  // Combinational decode of the incoming word into a buffer record.
  always_comb begin
    rec_d        = '0;
    rec_d.pc     = bus.in_pc;
    rec_d.opcode = instr[6:0];
    rec_d.func3  = instr[14:12];
    rec_d.func7  = instr[31:25];
    rec_d.rs1    = instr[19:15];
    rec_d.rs2    = instr[24:20];
    rec_d.rd     = instr[11:7];
    case (instr[6:0])
      OP_LUI, OP_AUIPC:                                   rec_d.fmt = FMT_U;
      OP_JAL:                                             rec_d.fmt = FMT_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM:      rec_d.fmt = FMT_I;
      OP_BRANCH:                                          rec_d.fmt = FMT_B;
      OP_STORE:                                           rec_d.fmt = FMT_S;
      OP_REG:                                             rec_d.fmt = FMT_R;
      default:                                            rec_d.fmt = FMT_INV;
    endcase
    case (rec_d.fmt)
      FMT_I:   rec_d.imm = sext32({{20{instr[31]}}, instr[31:20]});
      FMT_S:   rec_d.imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
      FMT_B:   rec_d.imm = sext32({{19{instr[31]}}, instr[31], instr[7],
                                   instr[30:25], instr[11:8], 1'b0});
      FMT_U:   rec_d.imm = sext32({instr[31:12], 12'b0});
      FMT_J:   rec_d.imm = sext32({{11{instr[31]}}, instr[31], instr[19:12],
                                   instr[20], instr[30:21], 1'b0});
      default: rec_d.imm = '0;
    endcase
`ifdef DECODE_ILLEGAL_EN
    rec_d.illegal = (rec_d.fmt == FMT_INV) || (instr[1:0] != 2'b11);
`endif
  end

  // Ready reflects stored occupancy only; reset and flush block acceptance.
  assign bus.in_ready = rst_n && !flush && (count_q < CW'(DEPTH));
  assign head_vld     = rst_n && (count_q != '0);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = head_vld && bus.out_ready && !flush;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Record storage needs no reset: occupancy masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rec_d;
  end

  always_comb begin
    out_rec = '0;
    if (head_vld) out_rec = mem[rd_ptr_q];
  end

  assign bus.out_valid  = head_vld;
  assign bus.out_pc     = out_rec.pc;
  assign bus.out_opcode = out_rec.opcode;
  assign bus.out_func3  = out_rec.func3;
  assign bus.out_func7  = out_rec.func7;
  assign bus.out_rs1    = out_rec.rs1;
  assign bus.out_rs2    = out_rec.rs2;
  assign bus.out_rd     = out_rec.rd;
  assign bus.out_imm    = out_rec.imm;
  assign bus.out_fmt    = out_rec.fmt;
`ifdef DECODE_ILLEGAL_EN
  assign bus.out_illegal = out_rec.illegal;
`else
  assign bus.out_illegal = 1'b0;
`endif

endmodule
